// File: rtl/pt_pkg.sv
// Shared definitions for the Pan-Tompkins stage sequencer.
// The package holds the sequencer state encoding, the chain position of each
// filter stage and the default sizing parameters.
package pt_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pt_state_e;

    // Position of each filter in the chain. This is also its bit in stage_en.
    localparam int STG_LPF = 0;
    localparam int STG_HPF = 1;
    localparam int STG_DER = 2;
    localparam int STG_SQR = 3;
    localparam int STG_MWI = 4;

    // Default sizing
    localparam int PT_NB_STAGES = 5;
    localparam int PT_WARMUP    = 32;
    localparam int PT_CNT_WIDTH = 6;

endpackage : pt_pkg

// File: rtl/pt_sat_counter.sv
// Saturating up-counter with count enable, synchronous clear and a registered
// terminal flag. The count stops at MAX and never wraps.
//
// Ports:
//   clk   in   system clock, rising edge
//   rstn  in   asynchronous active-low reset
//   clr   in   synchronous clear; takes priority over en
//   en    in   count by one this cycle (ignored once MAX is reached)
//   term  out  registered flag, high while the count equals MAX
module pt_sat_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             term_r;

    // Next count: clear first, otherwise step until the saturation value
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = ZERO_C;
        end else if (en && (count_r != MAX_C)) begin
            count_s = count_r + ONE_C;
        end else begin
            count_s = count_r;
        end
    end

    // Count and terminal-flag registers; the flag is computed from the next
    // count so it lines up with the count register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= ZERO_C;
            term_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            term_r  <= (count_s == MAX_C);
        end
    end

    assign term = term_r;

endmodule : pt_sat_counter

// File: rtl/pt_stage_sequencer.sv
// Pan-Tompkins filter chain sequencer. Each accepted ECG sample is walked
// through the chain (LPF, HPF, derivative, squaring, MWI) with one one-cycle
// enable strobe per stage and one stage per clock. A done pulse follows the
// last strobe. A saturating warm-up count of completed samples marks when the
// filter delay lines are full. After that point, done pulses are also
// reported as out_valid.
//
// Ports:
//   clk           in   system clock, rising edge
//   rstn          in   asynchronous active-low reset
//   en            in   global enable; low freezes the sequencer
//   clr           in   synchronous soft clear
//   sample_valid  in   new ADC sample present
//   sample_ready  out  sample can be accepted this cycle
//   stage_en      out  one-hot stage strobes, bit 0 = low-pass
//   sample_done   out  one-cycle pulse after the last stage strobe
//   out_valid     out  sample_done of a sample taken after warm-up
//   primed        out  warm-up complete
//   busy          out  sequence in progress
//   overrun       out  sticky: a sample was offered while not ready
//
// CNT_WIDTH must satisfy 2**CNT_WIDTH > WARMUP.
module pt_stage_sequencer
    import pt_pkg::*;
#(
    parameter int NB_STAGES = PT_NB_STAGES,
    parameter int WARMUP    = PT_WARMUP,
    parameter int CNT_WIDTH = PT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic [NB_STAGES-1:0] stage_en,
    output logic                 sample_done,
    output logic                 out_valid,
    output logic                 primed,
    output logic                 busy,
    output logic                 overrun
);

    localparam int IDX_W = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1;
    localparam logic [IDX_W-1:0]     IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_FIRST = IDX_W'(STG_LPF);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NB_STAGES - 1);
    localparam logic [NB_STAGES-1:0] STG_ZERO  = NB_STAGES'(0);
    localparam logic [NB_STAGES-1:0] STG_ONE   = NB_STAGES'(1);

    pt_state_e            state_r;
    pt_state_e            state_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_s;
    logic [NB_STAGES-1:0] stage_en_r;
    logic [NB_STAGES-1:0] stage_en_s;
    logic                 done_r;
    logic                 done_s;
    logic                 oval_r;
    logic                 oval_s;
    logic                 busy_r;
    logic                 overrun_r;
    logic                 overrun_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 cnt_inc_s;
    logic                 primed_s;

    // Ready depends only on the state and the live controls. The rstn term
    // keeps it low while reset is held.
    assign ready_s   = (state_r == ST_IDLE) & en & ~clr & rstn;
    assign accept_s  = sample_valid & ready_s;
    // A done pulse counts only when it is actually delivered (en high)
    assign cnt_inc_s = (state_r == ST_DONE) & en & ~clr;

    // Next-state and next-strobe logic. With en low everything holds, so a
    // strobe pending at the freeze is presented again once en returns.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        stage_en_s = stage_en_r;
        done_s     = done_r;
        oval_s     = oval_r;
        if (clr) begin
            state_s    = ST_IDLE;
            idx_s      = IDX_ZERO;
            stage_en_s = STG_ZERO;
            done_s     = 1'b0;
            oval_s     = 1'b0;
        end else if (!en) begin
            state_s    = state_r;
            idx_s      = idx_r;
            stage_en_s = stage_en_r;
            done_s     = done_r;
            oval_s     = oval_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s    = ST_RUN;
                        idx_s      = IDX_FIRST;
                        stage_en_s = STG_ONE << IDX_FIRST;
                    end else begin
                        stage_en_s = STG_ZERO;
                    end
                    done_s = 1'b0;
                    oval_s = 1'b0;
                end
                ST_RUN: begin
                    if (idx_r == IDX_LAST) begin
                        state_s    = ST_DONE;
                        stage_en_s = STG_ZERO;
                        done_s     = 1'b1;
                        // The warm-up count cannot change between here and
                        // the done pulse, so the current primed flag is the
                        // value seen before this sample's increment.
                        oval_s     = primed_s;
                    end else begin
                        idx_s      = idx_r + IDX_ONE;
                        stage_en_s = STG_ONE << (idx_r + IDX_ONE);
                        done_s     = 1'b0;
                        oval_s     = 1'b0;
                    end
                end
                ST_DONE: begin
                    state_s    = ST_IDLE;
                    idx_s      = IDX_ZERO;
                    stage_en_s = STG_ZERO;
                    done_s     = 1'b0;
                    oval_s     = 1'b0;
                end
                default: begin
                    state_s    = ST_IDLE;
                    idx_s      = IDX_ZERO;
                    stage_en_s = STG_ZERO;
                    done_s     = 1'b0;
                    oval_s     = 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: set on a sample offered while not ready, clear on clr.
    // A sample offered during clr does not set it.
    always_comb begin
        overrun_s = overrun_r;
        if (clr) begin
            overrun_s = 1'b0;
        end else if (sample_valid && en && !ready_s) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State, index and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            stage_en_r <= STG_ZERO;
            done_r     <= 1'b0;
            oval_r     <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            stage_en_r <= stage_en_s;
            done_r     <= done_s;
            oval_r     <= oval_s;
            busy_r     <= (state_s != ST_IDLE);
            overrun_r  <= overrun_s;
        end
    end

    // Count of completed samples since reset or clr
    pt_sat_counter #(
        .WIDTH (CNT_WIDTH),
        .MAX   (WARMUP)
    ) u_warmup (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .en    (cnt_inc_s),
        .term  (primed_s)
    );

    // Strobes are masked by en so nothing downstream fires while frozen
    assign sample_ready = ready_s;
    assign stage_en     = stage_en_r & {NB_STAGES{en}};
    assign sample_done  = done_r & en;
    assign out_valid    = oval_r & en;
    assign primed       = primed_s;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

endmodule : pt_stage_sequencer
